// File: rtl/dbus_sram_pkg.sv
// Shared types for the dbus SRAM responder: FSM state encoding and wait-counter width.
// Optional address fault checking is enabled by defining DBUS_ADDR_CHECK_EN.
package dbus_sram_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    function automatic logic is_wr_state(input state_e s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter that times SRAM strobe widths; loaded on state entry, zero flag ends the phase.
module sram_wait_counter
    import dbus_sram_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dbus_sram_responder.sv
// CPU data-bus to asynchronous SRAM bridge with stall handshake and registered strobes.
// Define DBUS_ADDR_CHECK_EN to fault accesses above the decoded address range.
module dbus_sram_responder
    import dbus_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dbus_address,
    input  logic [3:0]           dbus_byteenable,
    input  logic                 dbus_read,
    input  logic                 dbus_write,
    input  logic [31:0]          dbus_wrdata,
    output logic [31:0]          dbus_rddata,
    output logic                 dbus_stall,
    output logic                 dbus_err,
    output logic [ADDR_BITS-3:0] ram_address,
    output logic [31:0]          ram_data_o,
    output logic                 ram_data_oe,
    input  logic [31:0]          ram_data_i,
    output logic                 ram_ce_n,
    output logic                 ram_oe_n,
    output logic                 ram_we_n,
    output logic [3:0]           ram_be_n
);

    state_e               state_q;
    state_e               state_d;
    logic [ADDR_BITS-3:0] addr_q;
    logic [31:0]          wrdata_q;
    logic [31:0]          rddata_q;
    logic [3:0]           be_n_q;
    logic                 ce_n_q;
    logic                 oe_n_q;
    logic                 we_n_q;
    logic                 data_oe_q;
    logic                 req;
    logic                 fault;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_zero;

    assign req = dbus_read | dbus_write;

`ifdef DBUS_ADDR_CHECK_EN
    logic err_q;

    assign fault = |dbus_address[31:ADDR_BITS];

    // Fault is decided in IDLE, so the flag lands exactly on the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && req && fault;
        end
    end

    assign dbus_err = err_q;
`else
    assign fault    = 1'b0;
    assign dbus_err = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbus_address[31:ADDR_BITS], dbus_address[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (fault)           state_d = DONE;
                    else if (dbus_write) state_d = WR_SETUP;
                    else                 state_d = RD_ACCESS;
                end
            end
            RD_ACCESS: if (cnt_zero) state_d = DONE;
            WR_SETUP:  state_d = WR_PULSE;
            WR_PULSE:  if (cnt_zero) state_d = WR_HOLD;
            WR_HOLD:   state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign cnt_load = (state_d != state_q) && ((state_d == RD_ACCESS) || (state_d == WR_PULSE));
    assign cnt_en   = (state_q == RD_ACCESS) || (state_q == WR_PULSE);

    sram_wait_counter u_wait_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WAIT_CYCLES - 1)),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // Strobes are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            be_n_q    <= 4'hF;
            rddata_q  <= '0;
        end else begin
            state_q   <= state_d;
            ce_n_q    <= !((state_d == RD_ACCESS) || is_wr_state(state_d));
            oe_n_q    <= (state_d != RD_ACCESS);
            we_n_q    <= (state_d != WR_PULSE);
            data_oe_q <= is_wr_state(state_d);
            if ((state_q == IDLE) && req) begin
                be_n_q <= ~dbus_byteenable;
            end
            if ((state_q == RD_ACCESS) && cnt_zero) begin
                rddata_q <= ram_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && req) begin
            addr_q   <= dbus_address[ADDR_BITS-1:2];
            wrdata_q <= dbus_wrdata;
        end
    end

    assign dbus_stall  = req && (state_q != DONE);
    assign dbus_rddata = rddata_q;
    assign ram_address = addr_q;
    assign ram_data_o  = wrdata_q;
    assign ram_data_oe = data_oe_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign ram_be_n    = be_n_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder with a read-data scoreboard and strobe-width counting.
`timescale 1ns/1ps
module tb_dbus_sram_responder;

    localparam int WAIT = 2;
    localparam int AB   = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   dbus_address = '0;
    logic [3:0]    dbus_byteenable = '0;
    logic          dbus_read = 1'b0;
    logic          dbus_write = 1'b0;
    logic [31:0]   dbus_wrdata = '0;
    logic [31:0]   dbus_rddata;
    logic          dbus_stall;
    logic          dbus_err;
    logic [AB-3:0] ram_address;
    logic [31:0]   ram_data_o;
    logic          ram_data_oe;
    logic [31:0]   ram_data_i = '0;
    logic          ram_ce_n;
    logic          ram_oe_n;
    logic          ram_we_n;
    logic [3:0]    ram_be_n;

    dbus_sram_responder #(.WAIT_CYCLES(WAIT), .ADDR_BITS(AB)) dut (
        .clk             (clk),
        .rst             (rst),
        .dbus_address    (dbus_address),
        .dbus_byteenable (dbus_byteenable),
        .dbus_read       (dbus_read),
        .dbus_write      (dbus_write),
        .dbus_wrdata     (dbus_wrdata),
        .dbus_rddata     (dbus_rddata),
        .dbus_stall      (dbus_stall),
        .dbus_err        (dbus_err),
        .ram_address     (ram_address),
        .ram_data_o      (ram_data_o),
        .ram_data_oe     (ram_data_oe),
        .ram_data_i      (ram_data_i),
        .ram_ce_n        (ram_ce_n),
        .ram_oe_n        (ram_oe_n),
        .ram_we_n        (ram_we_n),
        .ram_be_n        (ram_be_n)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   model_rd = '0;
    int            stall_n, oe_low_n, we_low_n, ce_low_n, doe_n, overlap_n, err_n;
    logic [AB-3:0] seen_addr;
    logic [3:0]    seen_be;
    logic [31:0]   seen_wd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access observed over a fixed window; drop_after>0 releases the request early.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input int drop_after);
        logic        held;
        logic        done_seen;
        logic        flt;
        logic [31:0] exp_rd;
        stall_n = 0; oe_low_n = 0; we_low_n = 0; ce_low_n = 0;
        doe_n = 0; overlap_n = 0; err_n = 0;
        seen_addr = '0; seen_be = '0; seen_wd = '0;
        done_seen = 1'b0;
        flt = 1'b0;
`ifdef DBUS_ADDR_CHECK_EN
        flt = (addr[31:AB] != '0);
`endif
        if (rd && !wr && !flt) exp_q.push_back(rdat);
        else                   exp_q.push_back(model_rd);
        @(posedge clk); #1;
        dbus_read = rd; dbus_write = wr; dbus_address = addr;
        dbus_byteenable = be; dbus_wrdata = wd; ram_data_i = rdat;
        held = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (held && dbus_stall) stall_n++;
            if (!ram_ce_n) ce_low_n++;
            if (!ram_oe_n) begin
                oe_low_n++;
                seen_addr = ram_address;
                seen_be = ram_be_n;
            end
            if (!ram_we_n) begin
                we_low_n++;
                seen_addr = ram_address;
                seen_be = ram_be_n;
                seen_wd = ram_data_o;
            end
            if (ram_data_oe) doe_n++;
            if (ram_data_oe && !ram_oe_n) overlap_n++;
            if (dbus_err) err_n++;
            if (held && !dbus_stall && !done_seen) begin
                done_seen = 1'b1;
                exp_rd = exp_q.pop_front();
                check({tag, " rddata"}, dbus_rddata, exp_rd);
                model_rd = exp_rd;
            end
            @(posedge clk); #1;
            if (held && (done_seen || (drop_after > 0 && cyc == drop_after - 1))) begin
                held = 1'b0;
                dbus_read = 1'b0;
                dbus_write = 1'b0;
            end
        end
        if (!done_seen) begin
            exp_rd = exp_q.pop_front();
            check({tag, " rddata end"}, dbus_rddata, exp_rd);
            model_rd = exp_rd;
        end
        check({tag, " idle strobes"}, {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
        check({tag, " oe overlap"}, overlap_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int we_cnt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ce_n", ram_ce_n, 1'b1);
        check("rst oe_n", ram_oe_n, 1'b1);
        check("rst we_n", ram_we_n, 1'b1);
        check("rst be_n", ram_be_n, 4'hF);
        check("rst data_oe", ram_data_oe, 1'b0);
        check("rst rddata", dbus_rddata, 32'h0);
        check("rst err", dbus_err, 1'b0);
        check("rst stall idle", dbus_stall, 1'b0);
        dbus_read = 1'b1;
        #1;
        check("rst stall req", dbus_stall, 1'b1);
        dbus_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_access("rd", 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        check("rd stall", stall_n, WAIT + 1);
        check("rd oe_low", oe_low_n, WAIT);
        check("rd ce_low", ce_low_n, WAIT);
        check("rd we_low", we_low_n, 0);
        check("rd data_oe", doe_n, 0);
        check("rd addr", seen_addr, 18'h4);

        run_access("wr", 1'b0, 1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 32'h0BAD_0BAD, 0);
        check("wr stall", stall_n, WAIT + 3);
        check("wr we_low", we_low_n, WAIT);
        check("wr oe_low", oe_low_n, 0);
        check("wr ce_low", ce_low_n, WAIT + 2);
        check("wr data_oe", doe_n, WAIT + 2);
        check("wr addr", seen_addr, 18'h8);
        check("wr be_n", seen_be, 4'b1100);
        check("wr data", seen_wd, 32'h1234_5678);

        run_access("both", 1'b1, 1'b1, 32'h0000_0044, 4'b1000, 32'hCAFE_F00D, 32'h1111_1111, 0);
        check("both oe_low", oe_low_n, 0);
        check("both we_low", we_low_n, WAIT);
        check("both stall", stall_n, WAIT + 3);
        check("both addr", seen_addr, 18'h11);
        check("both be_n", seen_be, 4'b0111);

        run_access("drop", 1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'hA5A5_A5A5, 32'h0, 1);
        check("drop stall", stall_n, 1);
        check("drop we_low", we_low_n, WAIT);
        check("drop data_oe", doe_n, WAIT + 2);
        check("drop data", seen_wd, 32'hA5A5_A5A5);

        run_access("rd_top", 1'b1, 1'b0, 32'h000F_FFFC, 4'hF, 32'h0, 32'h5A5A_A5A5, 0);
        check("rd_top addr", seen_addr, 18'h3FFFF);
        check("rd_top stall", stall_n, WAIT + 1);

        run_access("hi_addr", 1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0, 32'h7777_7777, 0);
`ifdef DBUS_ADDR_CHECK_EN
        check("fault ce_low", ce_low_n, 0);
        check("fault stall", stall_n, 1);
        check("fault err", err_n, 1);
`else
        check("alias stall", stall_n, WAIT + 1);
        check("alias err", err_n, 0);
        check("alias addr", seen_addr, 18'h4);
`endif

        // Back-to-back reads with the request held through DONE.
        @(posedge clk); #1;
        dbus_read = 1'b1; dbus_address = 32'h0000_0030; ram_data_i = 32'h0102_0304;
        guard = 0;
        @(negedge clk);
        while (dbus_stall && guard < 20) begin @(negedge clk); guard++; end
        check("b2b first done", guard < 20, 1'b1);
        check("b2b first rddata", dbus_rddata, 32'h0102_0304);
        @(negedge clk);
        check("b2b idle stall", dbus_stall, 1'b1);
        check("b2b idle ce_n", ram_ce_n, 1'b1);
        ram_data_i = 32'h0A0B_0C0D;
        @(negedge clk);
        check("b2b second ce_n", ram_ce_n, 1'b0);
        guard = 0;
        while (dbus_stall && guard < 20) begin @(negedge clk); guard++; end
        check("b2b second done", guard < 20, 1'b1);
        check("b2b second rddata", dbus_rddata, 32'h0A0B_0C0D);
        @(posedge clk); #1;
        dbus_read = 1'b0;
        model_rd = 32'h0A0B_0C0D;

        // Reset in the second write-pulse cycle.
        @(posedge clk); #1;
        dbus_write = 1'b1; dbus_address = 32'h0000_0040;
        dbus_wrdata = 32'hFFFF_0000; dbus_byteenable = 4'hF;
        guard = 0; we_cnt = 0;
        while (we_cnt < 2 && guard < 20) begin
            @(negedge clk); guard++;
            if (!ram_we_n) we_cnt++;
        end
        check("rstmid reached pulse2", we_cnt, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid we_n", ram_we_n, 1'b1);
        check("rstmid data_oe", ram_data_oe, 1'b0);
        check("rstmid ce_n", ram_ce_n, 1'b1);
        check("rstmid rddata", dbus_rddata, 32'h0);
        check("rstmid stall", dbus_stall, 1'b1);
        dbus_write = 1'b0;
        rst = 1'b0;
        model_rd = 32'h0;
        @(negedge clk);
        check("rstmid idle strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
        check("rstmid idle stall", dbus_stall, 1'b0);

        run_access("post_rst", 1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 32'h1357_9BDF, 0);
        check("post_rst stall", stall_n, WAIT + 1);
        check("post_rst addr", seen_addr, 18'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
